pipelined_control_unit: RTL and testbench
=========================================

# pipelined_control_unit

Registered successor of the RV32I decode-stage control unit. It decodes `OP_D`/`F3_D`/`F7_D` into the control bundle and carries that bundle through the E, M and W pipeline registers. It resolves branches in E and optionally decodes the M extension, holding the E stage for a parameterised number of cycles per multiply/divide. It sits beside the datapath pipeline registers and feeds the hazard unit through `RES_SRC_E`, `REG_WRITE_M`/`REG_WRITE_W` and `MD_STALL`.

## Interface
- `ENABLE_M`, default 1: 1 decodes MUL/DIV (`OP=0110011`, `F7=0000001`); 0 treats them as illegal.
- `MUL_CYCLES`, default 2: E-stage occupancy of MUL/MULH/MULHSU/MULHU (f3 000–011). Must be ≥1.
- `DIV_CYCLES`, default 34: E-stage occupancy of DIV/DIVU/REM/REMU (f3 100–111). Must be ≥1.

Ports:
- `CLK` in 1: single clock; all state on rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `OP_D` in 7, `F3_D` in 3, `F7_D` in 7: instruction fields in D.
- `FLUSH_E` in 1: load a bubble into the E register.
- `ZERO_E` in 1: ALU zero flag for the instruction in E.
- `ALU_LSB_E` in 1: ALU result bit 0 (SLT/SLTU outcome) in E.
- `IMM_SRC_D` out 3: immediate format (000 I, 001 S, 010 B, 011 U, 100 J); combinational.
- `ILLEGAL_D` out 1: unsupported encoding in D; combinational.
- `ALU_CONTROL_E` out 5, `ALU_SRC_E` out 1, `RES_SRC_E` out 2: registered E controls.
- `PC_SRC_E` out 1: take branch/jump target.
- `JALR_E` out 1: target is the ALU result rather than PC+imm.
- `MEM_WRITE_M` out 1, `REG_WRITE_M` out 1, `RES_SRC_M` out 2: registered M controls.
- `REG_WRITE_W` out 1, `RES_SRC_W` out 2: registered W controls.
- `MD_STALL` out 1: E holds a multi-cycle op; the hazard unit stalls F/D.

## Operation
- Bundle fields: REG_WRITE, RES_SRC, MEM_WRITE, JUMP, BRANCH, JALR, ALU_CONTROL, ALU_SRC, F3.
- Bubble: every field 0.
- ALU codes, zero-extended to 5 bits:
  - add 00000, sub 00001, and 00100, or 00101, xor 00110
  - slt 01000, sltu 01001, srl 01101, sll 01110, sra 01111
  - M ops `{2'b10,F3}`
- Decode per opcode:
  - Load: RES 01, imm I, SRC 1, add, RW 1.
  - OP-IMM: RES 00, I, SRC 1, RW 1; ALU code by f3.
    - f3 001 requires F7=0000000.
    - f3 101 requires F7 = 0000000 (srl) or 0100000 (sra).
  - Store: MW 1, S, SRC 1, add.
  - AUIPC: RES 11, U, RW 1.
  - R-type: RES 00, SRC 0, RW 1.
    - F7=0100000 is allowed only with f3 000 (sub) or 101 (sra).
    - F7=0000001 is legal only if `ENABLE_M`.
  - LUI: RES 00, U, SRC 1, add, RW 1.
  - Branch: B, SRC 0, BRANCH 1.
    - f3 000/001 use sub; 100/101 use slt; 110/111 use sltu.
    - f3 010/011 are illegal.
  - JALR: RES 10, I, SRC 1, add, JUMP 1, JALR 1, RW 1.
  - JAL: RES 10, J, JUMP 1, RW 1.
- Illegal or unknown encoding: `ILLEGAL_D`=1, bubble bundle, `IMM_SRC_D`=000. No X is ever driven.
- `PC_SRC_E` = JUMP_E | (BRANCH_E & cond), where cond by F3_E is:
  - 000: ZERO
  - 001: !ZERO
  - 100/110: ALU_LSB
  - 101/111: !ALU_LSB
- Multi-cycle FSM, states IDLE and BUSY, with a down-counter of width clog2(max(MUL_CYCLES, DIV_CYCLES)).
  - L is the latency of the op in E.
  - `MD_STALL` = (IDLE & M-op in E & L>1) | (BUSY & cnt≠0).
  - IDLE→BUSY when `MD_STALL`; cnt loads L−2.
  - BUSY: cnt decrements each cycle; at cnt=0, BUSY→IDLE.
  - A back-to-back M op re-enters from IDLE on the next cycle.
- Per-edge update:
  - `MD_STALL`=1: E register holds and the M register loads a bubble. `FLUSH_E` is ignored.
  - Otherwise: E loads bubble if `FLUSH_E`, else the D bundle. M←E and W←M.

## Timing
- `RST` asserted: E, M, W bundles are bubbles and the FSM is IDLE, immediately and asynchronously. All registered outputs are 0, and `PC_SRC_E`=0 and `MD_STALL`=0.
- Reset mid-BUSY aborts the operation; no state is retained.
- D→E, E→M and M→W are each one edge.
- The D outputs are purely combinational.
- `PC_SRC_E` is combinational from the E register and flags, valid the same cycle.
- An M op entering E at edge t asserts `MD_STALL` for L−1 cycles, then advances to M one edge later.
- L=1 behaves exactly like a base ALU op.
- Simultaneous `FLUSH_E` and `MD_STALL`: stall wins.

## Test plan
- `add` (`0110011`/000/0000000): `ALU_CONTROL_E`=00000 at edge 1, `REG_WRITE_M`=1 at edge 2, `REG_WRITE_W`=1 at edge 3, `RES_SRC_W`=00.
- `bne` (f3 001) with `ZERO_E`=0: `PC_SRC_E`=1. `blt` (f3 100) with `ALU_LSB_E`=0: `PC_SRC_E`=0. `jalr`: `PC_SRC_E`=1, `JALR_E`=1, `RES_SRC_E`=10.
- `div` with `DIV_CYCLES`=4: `MD_STALL`=1 for exactly 3 cycles, `ALU_CONTROL_E`=10100 held throughout, 3 bubbles reach M, then `REG_WRITE_M`=1. Back-to-back `mul` with `MUL_CYCLES`=2 adds 1 more stall cycle.
- `FLUSH_E` with a store in D: `MEM_WRITE_M`=0 two edges later. `FLUSH_E` during `MD_STALL`: the E op survives.
- `OP_D`=`1111111`, sll with F7=0100000, and `ENABLE_M`=0 with `mul`: `ILLEGAL_D`=1 and the bundle is all zero downstream.
- Assert `RST` in cycle 2 of a DIV: all outputs 0 asynchronously, FSM IDLE. The first instruction after release decodes normally.

Source files
------------

// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - decode fields, pipeline controls and stall flag of the RV32I control unit
interface pipelined_control_unit_if;
    logic [6:0] OP_D;
    logic [2:0] F3_D;
    logic [6:0] F7_D;
    logic       FLUSH_E;
    logic       ZERO_E;
    logic       ALU_LSB_E;
    logic [2:0] IMM_SRC_D;
    logic       ILLEGAL_D;
    logic [4:0] ALU_CONTROL_E;
    logic       ALU_SRC_E;
    logic [1:0] RES_SRC_E;
    logic       PC_SRC_E;
    logic       JALR_E;
    logic       MEM_WRITE_M;
    logic       REG_WRITE_M;
    logic [1:0] RES_SRC_M;
    logic       REG_WRITE_W;
    logic [1:0] RES_SRC_W;
    logic       MD_STALL;

    modport master (
        output OP_D, F3_D, F7_D, FLUSH_E, ZERO_E, ALU_LSB_E,
        input  IMM_SRC_D, ILLEGAL_D, ALU_CONTROL_E, ALU_SRC_E, RES_SRC_E, PC_SRC_E, JALR_E,
        input  MEM_WRITE_M, REG_WRITE_M, RES_SRC_M, REG_WRITE_W, RES_SRC_W, MD_STALL
    );

    modport slave (
        input  OP_D, F3_D, F7_D, FLUSH_E, ZERO_E, ALU_LSB_E,
        output IMM_SRC_D, ILLEGAL_D, ALU_CONTROL_E, ALU_SRC_E, RES_SRC_E, PC_SRC_E, JALR_E,
        output MEM_WRITE_M, REG_WRITE_M, RES_SRC_M, REG_WRITE_W, RES_SRC_W, MD_STALL
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - RV32I(M) decode with E/M/W control registers and multi-cycle M-op stall
module pipelined_control_unit #(
    parameter bit ENABLE_M   = 1'b1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 34
) (
    input  logic CLK,
    input  logic RST,
    pipelined_control_unit_if.slave bus
);
    typedef struct packed {
        logic       reg_write;
        logic [1:0] res_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       jalr;
        logic [4:0] alu_control;
        logic       alu_src;
        logic [2:0] f3;
    } ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] res_src;
        logic       mem_write;
    } mctl_t;

    typedef enum logic {S_IDLE, S_BUSY} md_state_t;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00100;
    localparam logic [4:0] ALU_OR   = 5'b00101;
    localparam logic [4:0] ALU_XOR  = 5'b00110;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;
    localparam logic [4:0] ALU_SRL  = 5'b01101;
    localparam logic [4:0] ALU_SLL  = 5'b01110;
    localparam logic [4:0] ALU_SRA  = 5'b01111;

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] MUL_LOAD = (MUL_CYCLES > 1) ? CW'(MUL_CYCLES - 2) : '0;
    localparam logic [CW-1:0] DIV_LOAD = (DIV_CYCLES > 1) ? CW'(DIV_CYCLES - 2) : '0;

    ctrl_t      dec;
    logic [2:0] imm_d;
    logic       ill_d;
    ctrl_t      e_q;
    mctl_t      m_q;
    logic       w_reg_write;
    logic [1:0] w_res_src;
    md_state_t  state;
    logic [CW-1:0] cnt;
    logic       md_op_e, multi_e, md_stall, br_cond;

    always_comb begin
        dec    = '0;
        imm_d  = 3'b000;
        ill_d  = 1'b0;
        dec.f3 = bus.F3_D;
        case (bus.OP_D)
            7'b0000011: begin
                dec.res_src   = 2'b01;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            7'b0010011: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                case (bus.F3_D)
                    3'b000: dec.alu_control = ALU_ADD;
                    3'b010: dec.alu_control = ALU_SLT;
                    3'b011: dec.alu_control = ALU_SLTU;
                    3'b100: dec.alu_control = ALU_XOR;
                    3'b110: dec.alu_control = ALU_OR;
                    3'b001: begin
                        if (bus.F7_D == 7'b0000000) dec.alu_control = ALU_SLL;
                        else ill_d = 1'b1;
                    end
                    3'b101: begin
                        if (bus.F7_D == 7'b0000000)      dec.alu_control = ALU_SRL;
                        else if (bus.F7_D == 7'b0100000) dec.alu_control = ALU_SRA;
                        else ill_d = 1'b1;
                    end
                    default: dec.alu_control = ALU_AND;
                endcase
            end
            7'b0100011: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_d         = 3'b001;
            end
            7'b0010111: begin
                dec.res_src   = 2'b11;
                dec.reg_write = 1'b1;
                imm_d         = 3'b011;
            end
            7'b0110011: begin
                dec.reg_write = 1'b1;
                if (bus.F7_D == 7'b0000001) begin
                    if (ENABLE_M) dec.alu_control = {2'b10, bus.F3_D};
                    else ill_d = 1'b1;
                end else if (bus.F7_D == 7'b0100000) begin
                    if (bus.F3_D == 3'b000)      dec.alu_control = ALU_SUB;
                    else if (bus.F3_D == 3'b101) dec.alu_control = ALU_SRA;
                    else ill_d = 1'b1;
                end else if (bus.F7_D == 7'b0000000) begin
                    case (bus.F3_D)
                        3'b000:  dec.alu_control = ALU_ADD;
                        3'b001:  dec.alu_control = ALU_SLL;
                        3'b010:  dec.alu_control = ALU_SLT;
                        3'b011:  dec.alu_control = ALU_SLTU;
                        3'b100:  dec.alu_control = ALU_XOR;
                        3'b101:  dec.alu_control = ALU_SRL;
                        3'b110:  dec.alu_control = ALU_OR;
                        default: dec.alu_control = ALU_AND;
                    endcase
                end else begin
                    ill_d = 1'b1;
                end
            end
            7'b0110111: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                imm_d         = 3'b011;
            end
            7'b1100011: begin
                dec.branch = 1'b1;
                imm_d      = 3'b010;
                case (bus.F3_D)
                    3'b000, 3'b001: dec.alu_control = ALU_SUB;
                    3'b100, 3'b101: dec.alu_control = ALU_SLT;
                    3'b110, 3'b111: dec.alu_control = ALU_SLTU;
                    default:        ill_d = 1'b1;
                endcase
            end
            7'b1100111: begin
                dec.res_src   = 2'b10;
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
                dec.jalr      = 1'b1;
                dec.reg_write = 1'b1;
            end
            7'b1101111: begin
                dec.res_src   = 2'b10;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                imm_d         = 3'b100;
            end
            default: ill_d = 1'b1;
        endcase
        // Anything unsupported must leave the pipeline as a clean bubble
        if (ill_d) begin
            dec   = '0;
            imm_d = 3'b000;
        end
    end

    always_comb begin
        case (e_q.f3)
            3'b000:         br_cond = bus.ZERO_E;
            3'b001:         br_cond = !bus.ZERO_E;
            3'b100, 3'b110: br_cond = bus.ALU_LSB_E;
            3'b101, 3'b111: br_cond = !bus.ALU_LSB_E;
            default:        br_cond = 1'b0;
        endcase
    end

    assign md_op_e  = (e_q.alu_control[4:3] == 2'b10);
    assign multi_e  = e_q.f3[2] ? (DIV_CYCLES > 1) : (MUL_CYCLES > 1);
    assign md_stall = ((state == S_IDLE) && md_op_e && multi_e) || ((state == S_BUSY) && (cnt != '0));

    // A stalled E holds its op while bubbles drain into M; stall overrides FLUSH_E
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            e_q         <= '0;
            m_q         <= '0;
            w_reg_write <= 1'b0;
            w_res_src   <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (md_stall) begin
                        state <= S_BUSY;
                        cnt   <= e_q.f3[2] ? DIV_LOAD : MUL_LOAD;
                    end
                end
                default: begin
                    if (cnt == '0) state <= S_IDLE;
                    else cnt <= cnt - CW'(1);
                end
            endcase
            if (md_stall) begin
                m_q <= '0;
            end else begin
                e_q <= bus.FLUSH_E ? '0 : dec;
                m_q <= '{reg_write: e_q.reg_write, res_src: e_q.res_src, mem_write: e_q.mem_write};
            end
            w_reg_write <= m_q.reg_write;
            w_res_src   <= m_q.res_src;
        end
    end

    assign bus.IMM_SRC_D     = imm_d;
    assign bus.ILLEGAL_D     = ill_d;
    assign bus.ALU_CONTROL_E = e_q.alu_control;
    assign bus.ALU_SRC_E     = e_q.alu_src;
    assign bus.RES_SRC_E     = e_q.res_src;
    assign bus.PC_SRC_E      = e_q.jump | (e_q.branch & br_cond);
    assign bus.JALR_E        = e_q.jalr;
    assign bus.MEM_WRITE_M   = m_q.mem_write;
    assign bus.REG_WRITE_M   = m_q.reg_write;
    assign bus.RES_SRC_M     = m_q.res_src;
    assign bus.REG_WRITE_W   = w_reg_write;
    assign bus.RES_SRC_W     = w_res_src;
    assign bus.MD_STALL      = md_stall;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - vector table, pipeline scoreboard and multi-cycle sequences for pipelined_control_unit
module tb_pipelined_control_unit;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] imm;
        logic       ill;
        logic [4:0] alu;
        logic       src;
        logic [1:0] res;
        logic       rw;
        logic       mw;
        logic       pc;
        logic       jalr;
    } vec_t;

    logic CLK, RST;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    vec_t sb[$];

    pipelined_control_unit_if bus();
    pipelined_control_unit_if busn();

    pipelined_control_unit #(.ENABLE_M(1'b1), .MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .bus(bus));
    pipelined_control_unit #(.ENABLE_M(1'b0), .MUL_CYCLES(2), .DIV_CYCLES(4)) dut_nm (
        .CLK(CLK), .RST(RST), .bus(busn));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [2:0] imm, input logic ill, input logic [4:0] alu,
                                input logic src, input logic [1:0] res, input logic rw,
                                input logic mw, input logic pc, input logic jalr);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.imm = imm; v.ill = ill; v.alu = alu;
        v.src = src; v.res = res; v.rw = rw; v.mw = mw; v.pc = pc; v.jalr = jalr;
        return v;
    endfunction

    function automatic logic [17:0] outs();
        return {bus.ALU_CONTROL_E, bus.ALU_SRC_E, bus.RES_SRC_E, bus.PC_SRC_E, bus.JALR_E,
                bus.MEM_WRITE_M, bus.REG_WRITE_M, bus.RES_SRC_M, bus.REG_WRITE_W, bus.RES_SRC_W,
                bus.MD_STALL};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.OP_D = op;
        bus.F3_D = f3;
        bus.F7_D = f7;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stalls;
        int guard;
        vec_t e;

        RST = 1'b1;
        drive(OP_BAD, 3'b000, 7'b0);
        bus.FLUSH_E = 1'b0; bus.ZERO_E = 1'b0; bus.ALU_LSB_E = 1'b0;
        busn.OP_D = OP_BAD; busn.F3_D = 3'b000; busn.F7_D = 7'b0;
        busn.FLUSH_E = 1'b0; busn.ZERO_E = 1'b0; busn.ALU_LSB_E = 1'b0;

        tbl.push_back(mk(OP_R,    3'b000, 7'b0,   3'b000, 0, 5'b00000, 0, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(OP_R,    3'b000, F7_ALT, 3'b000, 0, 5'b00001, 0, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(OP_R,    3'b101, F7_ALT, 3'b000, 0, 5'b01111, 0, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(OP_R,    3'b011, 7'b0,   3'b000, 0, 5'b01001, 0, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(OP_R,    3'b110, 7'b0,   3'b000, 0, 5'b00101, 0, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(OP_L,    3'b010, 7'b0,   3'b000, 0, 5'b00000, 1, 2'b01, 1, 0, 0, 0));
        tbl.push_back(mk(OP_S,    3'b010, 7'b0,   3'b001, 0, 5'b00000, 1, 2'b00, 0, 1, 0, 0));
        tbl.push_back(mk(OP_I,    3'b100, 7'b0,   3'b000, 0, 5'b00110, 1, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(OP_I,    3'b001, 7'b0,   3'b000, 0, 5'b01110, 1, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(OP_I,    3'b101, F7_ALT, 3'b000, 0, 5'b01111, 1, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(OP_I,    3'b101, 7'b0,   3'b000, 0, 5'b01101, 1, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(OP_I,    3'b111, 7'b0,   3'b000, 0, 5'b00100, 1, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(OP_I,    3'b010, 7'b0,   3'b000, 0, 5'b01000, 1, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(OP_LUI,  3'b000, 7'b0,   3'b011, 0, 5'b00000, 1, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(OP_AUI,  3'b000, 7'b0,   3'b011, 0, 5'b00000, 0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(OP_B,    3'b000, 7'b0,   3'b010, 0, 5'b00001, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(OP_B,    3'b110, 7'b0,   3'b010, 0, 5'b01001, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(OP_JAL,  3'b000, 7'b0,   3'b100, 0, 5'b00000, 0, 2'b10, 1, 0, 1, 0));
        tbl.push_back(mk(OP_JALR, 3'b000, 7'b0,   3'b000, 0, 5'b00000, 1, 2'b10, 1, 0, 1, 1));
        tbl.push_back(mk(OP_BAD,  3'b000, 7'b0,   3'b000, 1, 5'b00000, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(OP_R,    3'b001, F7_ALT, 3'b000, 1, 5'b00000, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(OP_B,    3'b010, 7'b0,   3'b000, 1, 5'b00000, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(OP_I,    3'b001, F7_ALT, 3'b000, 1, 5'b00000, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(OP_R,    3'b000, 7'b0000010, 3'b000, 1, 5'b00000, 0, 2'b00, 0, 0, 0, 0));

        #12;
        chk("reset_outs", 32'(outs()), 32'h0);
        RST = 1'b0;

        // Vector table: one instruction per cycle, expected bundle tracked through E/M/W
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].op, tbl[i].f3, tbl[i].f7);
            #1;
            chk($sformatf("row%0d_imm", i), 32'(bus.IMM_SRC_D), 32'(tbl[i].imm));
            chk($sformatf("row%0d_ill", i), 32'(bus.ILLEGAL_D), 32'(tbl[i].ill));
            sb.push_back(tbl[i]);
            step();
            e = sb[$];
            chk($sformatf("row%0d_alu_e", i), 32'(bus.ALU_CONTROL_E), 32'(e.alu));
            chk($sformatf("row%0d_src_e", i), 32'(bus.ALU_SRC_E), 32'(e.src));
            chk($sformatf("row%0d_res_e", i), 32'(bus.RES_SRC_E), 32'(e.res));
            chk($sformatf("row%0d_pc_e", i), 32'(bus.PC_SRC_E), 32'(e.pc));
            chk($sformatf("row%0d_jalr_e", i), 32'(bus.JALR_E), 32'(e.jalr));
            if (sb.size() >= 2) begin
                e = sb[$-1];
                chk($sformatf("row%0d_m", i), 32'({bus.REG_WRITE_M, bus.RES_SRC_M, bus.MEM_WRITE_M}),
                    32'({e.rw, e.res, e.mw}));
            end
            if (sb.size() >= 3) begin
                e = sb[$-2];
                chk($sformatf("row%0d_w", i), 32'({bus.REG_WRITE_W, bus.RES_SRC_W}), 32'({e.rw, e.res}));
                void'(sb.pop_front());
            end
        end

        // Branch conditions react combinationally to the E flags
        drive(OP_B, 3'b001, 7'b0);
        step();
        bus.ZERO_E = 1'b0; #1;
        chk("bne_taken", 32'(bus.PC_SRC_E), 32'd1);
        bus.ZERO_E = 1'b1; #1;
        chk("bne_not_taken", 32'(bus.PC_SRC_E), 32'd0);
        drive(OP_B, 3'b100, 7'b0);
        step();
        bus.ALU_LSB_E = 1'b0; #1;
        chk("blt_not_taken", 32'(bus.PC_SRC_E), 32'd0);
        bus.ALU_LSB_E = 1'b1; #1;
        chk("blt_taken", 32'(bus.PC_SRC_E), 32'd1);
        bus.ZERO_E = 1'b0; bus.ALU_LSB_E = 1'b0;

        // DIV with 4-cycle latency, FLUSH_E asserted mid-stall
        drive(OP_R, 3'b100, F7_M);
        step();
        drive(OP_R, 3'b000, 7'b0);
        stalls = 0;
        guard  = 0;
        while (bus.MD_STALL && guard < 20) begin
            stalls++;
            guard++;
            chk("div_alu_held", 32'(bus.ALU_CONTROL_E), 32'b10100);
            bus.FLUSH_E = (stalls == 2);
            step();
            bus.FLUSH_E = 1'b0;
            chk("div_bubble_m", 32'(bus.REG_WRITE_M), 32'd0);
        end
        chk("div_stall_cycles", stalls, 3);
        chk("div_alu_after_stall", 32'(bus.ALU_CONTROL_E), 32'b10100);
        step();
        chk("div_reaches_m", 32'(bus.REG_WRITE_M), 32'd1);
        chk("div_next_in_e", 32'(bus.ALU_CONTROL_E), 32'b00000);

        // Back-to-back MUL with 2-cycle latency
        drive(OP_R, 3'b000, F7_M);
        step();
        stalls = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.MD_STALL) stalls++;
            if (k == 0) chk("mul_alu", 32'(bus.ALU_CONTROL_E), 32'b10000);
            if (k == 2) begin
                chk("mul1_reaches_m", 32'(bus.REG_WRITE_M), 32'd1);
                drive(OP_R, 3'b000, 7'b0);
            end
            step();
        end
        chk("mul_b2b_stall_cycles", stalls, 2);

        // Flushed store never writes memory
        drive(OP_S, 3'b010, 7'b0);
        bus.FLUSH_E = 1'b1;
        step();
        bus.FLUSH_E = 1'b0;
        drive(OP_BAD, 3'b000, 7'b0);
        chk("flush_e_bubble", 32'(outs() >> 9), 32'h0);
        step();
        chk("flush_mem_write_m", 32'(bus.MEM_WRITE_M), 32'd0);

        // M extension disabled: MUL is illegal
        drive(OP_R, 3'b000, F7_M);
        busn.OP_D = OP_R; busn.F3_D = 3'b000; busn.F7_D = F7_M;
        #1;
        chk("mul_legal_with_m", 32'(bus.ILLEGAL_D), 32'd0);
        chk("mul_illegal_no_m", 32'(busn.ILLEGAL_D), 32'd1);
        chk("mul_imm_no_m", 32'(busn.IMM_SRC_D), 32'd0);
        drive(OP_BAD, 3'b000, 7'b0);
        step();
        chk("nm_e_bubble", 32'({busn.ALU_CONTROL_E, busn.MD_STALL, busn.RES_SRC_E}), 32'h0);
        step();
        chk("nm_m_bubble", 32'(busn.REG_WRITE_M), 32'd0);

        // Reset asserted in the second cycle of a DIV
        drive(OP_R, 3'b100, F7_M);
        step();
        chk("rst_div_stall", 32'(bus.MD_STALL), 32'd1);
        drive(OP_R, 3'b000, 7'b0);
        step();
        #2 RST = 1'b1;
        #1;
        chk("rst_async_outs", 32'(outs()), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        step();
        chk("post_rst_alu", 32'(bus.ALU_CONTROL_E), 32'b00000);
        chk("post_rst_stall", 32'(bus.MD_STALL), 32'd0);
        step();
        chk("post_rst_m", 32'(bus.REG_WRITE_M), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
